// File: rtl/display_pkg.sv
// Shared sizing helpers, blank pixel value and bank-select type for the display scan engine.
package display_pkg;

    localparam int unsigned BLANK_MAX_W = 1024;
    localparam logic [BLANK_MAX_W-1:0] BLANK_PIXEL = '0;

    typedef enum logic {
        BANK0 = 1'b0,
        BANK1 = 1'b1
    } bank_sel_t;

    function automatic int unsigned pix_word_w(input int unsigned pix_w, input int unsigned num_ch);
        return pix_w * num_ch;
    endfunction

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    // Counter width for a count range of 'total' states (never below one bit)
    function automatic int unsigned cnt_w(input int unsigned total);
        return (total <= 32'd1) ? 32'd1 : 32'($clog2(total));
    endfunction

    function automatic bank_sel_t other_bank(input bank_sel_t b);
        return (b == BANK0) ? BANK1 : BANK0;
    endfunction

endpackage

// File: rtl/display_line_buf.sv
// Simple dual-port synchronous line RAM; registered read returns blank when not enabled.
module display_line_buf
    import display_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 24,
    parameter int unsigned AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= WIDTH'(BLANK_PIXEL);
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= WIDTH'(BLANK_PIXEL);
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/display_scan_engine.sv
// Ping-pong line-buffered display scan engine with programmable H/V timing.
// Optional colour-bar generator enabled by defining DISP_TEST_PATTERN_EN.
module display_scan_engine
    import display_pkg::*;
#(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned NUM_CH   = 3,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cs_display,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [pix_word_w(PIX_W, NUM_CH)-1:0] wr_data,
`ifdef DISP_TEST_PATTERN_EN
    input  logic                                 test_pattern,
`endif
    output logic                                 pix_de,
    output logic [pix_word_w(PIX_W, NUM_CH)-1:0] pix_data,
    output logic                                 hsync,
    output logic                                 vsync,
    output logic                                 frame_start,
    output logic                                 underrun,
    input  logic                                 clr_underrun
);

    localparam int unsigned PW      = pix_word_w(PIX_W, NUM_CH);
    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HCW     = cnt_w(H_TOTAL);
    localparam int unsigned VCW     = cnt_w(V_TOTAL);
    localparam int unsigned HXW     = HCW + 1;
    localparam int unsigned VXW     = VCW + 1;
    localparam int unsigned AW      = cnt_w(H_ACTIVE);
    localparam int unsigned CW      = cnt_w(H_ACTIVE + 1);

    // One extra bit so that totals and sync ends never truncate
    localparam logic [HXW-1:0] PX_LAST = HXW'(H_TOTAL - 1);
    localparam logic [HXW-1:0] H_ACT   = HXW'(H_ACTIVE);
    localparam logic [HXW-1:0] HS_BEG  = HXW'(H_ACTIVE + H_FP);
    localparam logic [HXW-1:0] HS_END  = HXW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VXW-1:0] LN_LAST = VXW'(V_TOTAL - 1);
    localparam logic [VXW-1:0] V_ACT   = VXW'(V_ACTIVE);
    localparam logic [VXW-1:0] VS_BEG  = VXW'(V_ACTIVE + V_FP);
    localparam logic [VXW-1:0] VS_END  = VXW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0]  CNT_FULL = CW'(H_ACTIVE);
    localparam logic [CW-1:0]  CNT_LAST = CW'(H_ACTIVE - 1);

    logic [HCW-1:0] r_px;
    logic [VCW-1:0] r_line;
    logic [CW-1:0]  r_cnt0;
    logic [CW-1:0]  r_cnt1;
    bank_sel_t      r_wr_bank;
    logic           r_rd_valid;

    logic           r_pix_de;
    logic           r_hsync;
    logic           r_vsync;
    logic           r_frame_start;
    logic           r_underrun;

    logic [HXW-1:0] w_px_x;
    logic [VXW-1:0] w_line_x;
    logic [VCW-1:0] w_line_next;
    logic           w_px_last;
    logic           w_swap_pt;
    logic           w_active;
    logic           w_hs;
    logic           w_vs;
    logic           w_frame0;

    logic [CW-1:0]  w_wr_cnt;
    logic [CW-1:0]  w_cnt0_nxt;
    logic [CW-1:0]  w_cnt1_nxt;
    logic           w_wr_ready;
    logic           w_wr_fire;
    logic           w_full;
    logic           w_do_swap;

    logic           w_pat_sel;
    logic           w_rd_en;
    logic           w_under;
    logic           w_we0;
    logic           w_we1;
    logic           w_re0;
    logic           w_re1;
    logic [AW-1:0]  w_waddr;
    logic [AW-1:0]  w_raddr;
    logic [PW-1:0]  w_q0;
    logic [PW-1:0]  w_q1;

    // Timing decode of the current counter state
    always_comb begin
        w_px_x      = HXW'(r_px);
        w_line_x    = VXW'(r_line);
        w_px_last   = (w_px_x == PX_LAST);
        w_line_next = (w_line_x == LN_LAST) ? '0 : r_line + VCW'(1);
        w_swap_pt   = w_px_last && (VXW'(w_line_next) < V_ACT);
        w_active    = (w_px_x < H_ACT) && (w_line_x < V_ACT);
        w_hs        = (w_px_x >= HS_BEG) && (w_px_x < HS_END);
        w_vs        = (w_line_x >= VS_BEG) && (w_line_x < VS_END);
        w_frame0    = (r_px == '0) && (r_line == '0);
    end

    // Write handshake and bank bookkeeping; a fill completing on the swap cycle still swaps
    always_comb begin
        w_wr_cnt   = (r_wr_bank == BANK0) ? r_cnt0 : r_cnt1;
        w_wr_ready = reset && cs_display && (w_wr_cnt < CNT_FULL);
        w_wr_fire  = wr_valid && w_wr_ready;
        w_full     = (w_wr_cnt == CNT_FULL) || (w_wr_fire && (w_wr_cnt == CNT_LAST));
        w_do_swap  = w_swap_pt && w_full;
        w_cnt0_nxt = r_cnt0;
        w_cnt1_nxt = r_cnt1;
        if (w_wr_fire) begin
            if (r_wr_bank == BANK0) begin
                w_cnt0_nxt = r_cnt0 + CW'(1);
            end else begin
                w_cnt1_nxt = r_cnt1 + CW'(1);
            end
        end
        if (w_do_swap) begin
            if (r_wr_bank == BANK0) begin
                w_cnt1_nxt = '0;
            end else begin
                w_cnt0_nxt = '0;
            end
        end
    end

    assign wr_ready = w_wr_ready;

`ifdef DISP_TEST_PATTERN_EN
    logic [31:0]   w_bar;
    logic [PW-1:0] w_pat_pix;
    logic [PW-1:0] r_pat_data;

    assign w_pat_sel = test_pattern;

    // Colour bars: bar index = px*8/H_ACTIVE, bit c of the index lights channel c
    always_comb begin
        w_bar     = (32'(r_px) * 32'd8) / H_ACTIVE;
        w_pat_pix = PW'(BLANK_PIXEL);
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (w_bar[c]) begin
                w_pat_pix[c*PIX_W +: PIX_W] = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat_data <= PW'(BLANK_PIXEL);
        end else if (cs_display && w_active && w_pat_sel) begin
            r_pat_data <= w_pat_pix;
        end else begin
            r_pat_data <= PW'(BLANK_PIXEL);
        end
    end
`else
    assign w_pat_sel = 1'b0;
`endif

    // Read port steering: the read bank is always the one not being written
    always_comb begin
        w_rd_en = cs_display && w_active && r_rd_valid && !w_pat_sel;
        w_under = cs_display && w_active && !r_rd_valid && !w_pat_sel;
        w_we0   = w_wr_fire && (r_wr_bank == BANK0);
        w_we1   = w_wr_fire && (r_wr_bank == BANK1);
        w_re0   = w_rd_en && (r_wr_bank == BANK1);
        w_re1   = w_rd_en && (r_wr_bank == BANK0);
        w_waddr = AW'(w_wr_cnt);
        w_raddr = AW'(r_px);
    end

    // Counters, bank roles and read-bank validity
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_px       <= '0;
            r_line     <= '0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
            r_wr_bank  <= BANK0;
            r_rd_valid <= 1'b0;
        end else if (!cs_display) begin
            r_px       <= '0;
            r_line     <= '0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_cnt0 <= w_cnt0_nxt;
            r_cnt1 <= w_cnt1_nxt;
            if (w_px_last) begin
                r_px       <= '0;
                r_line     <= w_line_next;
                r_rd_valid <= w_do_swap;
                if (w_do_swap) begin
                    r_wr_bank <= other_bank(r_wr_bank);
                end
            end else begin
                r_px <= r_px + HCW'(1);
            end
        end
    end

    // Video outputs lag the counter state by one cycle, matching the RAM read latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_de      <= 1'b0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            if (w_under) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
            if (!cs_display) begin
                r_pix_de      <= 1'b0;
                r_hsync       <= 1'b0;
                r_vsync       <= 1'b0;
                r_frame_start <= 1'b0;
            end else begin
                r_pix_de      <= w_active;
                r_hsync       <= w_hs;
                r_vsync       <= w_vs;
                r_frame_start <= w_frame0;
            end
        end
    end

    display_line_buf #(
        .DEPTH (H_ACTIVE),
        .WIDTH (PW),
        .AW    (AW)
    ) u_bank0 (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_we0),
        .i_waddr (w_waddr),
        .i_wdata (wr_data),
        .i_re    (w_re0),
        .i_raddr (w_raddr),
        .o_rdata (w_q0)
    );

    display_line_buf #(
        .DEPTH (H_ACTIVE),
        .WIDTH (PW),
        .AW    (AW)
    ) u_bank1 (
        .clk     (clk),
        .rst_n   (reset),
        .i_we    (w_we1),
        .i_waddr (w_waddr),
        .i_wdata (wr_data),
        .i_re    (w_re1),
        .i_raddr (w_raddr),
        .o_rdata (w_q1)
    );

    assign pix_de      = r_pix_de;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
`ifdef DISP_TEST_PATTERN_EN
    assign pix_data    = w_q0 | w_q1 | r_pat_data;
`else
    assign pix_data    = w_q0 | w_q1;
`endif

endmodule

// File: tb/tb_display_scan_engine.sv
// Directed bench for display_scan_engine on an 8x5 timing (4 active px, 2 active lines).
module tb_display_scan_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs_display = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [23:0] wr_data = '0;
    logic        pix_de;
    logic [23:0] pix_data;
    logic        hsync;
    logic        vsync;
    logic        frame_start;
    logic        underrun;
    logic        clr_underrun = 1'b0;
`ifdef DISP_TEST_PATTERN_EN
    logic        test_pattern = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    display_scan_engine #(
        .PIX_W(8), .NUM_CH(3),
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_display   (cs_display),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
`ifdef DISP_TEST_PATTERN_EN
        .test_pattern (test_pattern),
`endif
        .pix_de       (pix_de),
        .pix_data     (pix_data),
        .hsync        (hsync),
        .vsync        (vsync),
        .frame_start  (frame_start),
        .underrun     (underrun),
        .clr_underrun (clr_underrun)
    );

    // Expected outputs after the edge that processed counter state s (s = cycles since enable)
    function automatic logic m_de(input int s);
        return ((s % 8) < 4) && (((s / 8) % 5) < 2);
    endfunction
    function automatic logic m_hs(input int s);
        return (s % 8) == 5;
    endfunction
    function automatic logic m_vs(input int s);
        return ((s / 8) % 5) == 3;
    endfunction
    function automatic logic m_fs(input int s);
        return (s % 40) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Leaves reset released just before edge 1; edge k then processes state k-1
    task automatic do_reset();
        reset        = 1'b0;
        cs_display   = 1'b1;
        wr_valid     = 1'b0;
        wr_data      = '0;
        clr_underrun = 1'b0;
`ifdef DISP_TEST_PATTERN_EN
        test_pattern = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        #2;
        reset      = 1'b0;
        cs_display = 1'b1;
        wr_valid   = 1'b1;
        wr_data    = 24'hABCDEF;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready);
        end
        checks++;
        if ({pix_de, hsync, vsync, frame_start, underrun} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b exp=00000", {pix_de, hsync, vsync, frame_start, underrun});
        end
        checks++;
        if (pix_data !== 24'h0) begin
            errors++; $display("FAIL reset_pix_data got=%h exp=000000", pix_data);
        end
    endtask

    task automatic test_timing();
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            step();
            checks += 5;
            if (pix_de !== m_de(k - 1)) begin
                errors++; $display("FAIL timing_de cyc=%0d got=%b exp=%b", k, pix_de, m_de(k - 1));
            end
            if (hsync !== m_hs(k - 1)) begin
                errors++; $display("FAIL timing_hsync cyc=%0d got=%b exp=%b", k, hsync, m_hs(k - 1));
            end
            if (vsync !== m_vs(k - 1)) begin
                errors++; $display("FAIL timing_vsync cyc=%0d got=%b exp=%b", k, vsync, m_vs(k - 1));
            end
            if (frame_start !== m_fs(k - 1)) begin
                errors++; $display("FAIL timing_frame_start cyc=%0d got=%b exp=%b", k, frame_start, m_fs(k - 1));
            end
            if (pix_data !== 24'h0) begin
                errors++; $display("FAIL timing_blank cyc=%0d got=%h exp=000000", k, pix_data);
            end
            if (k == 1) begin
                checks++;
                if (underrun !== 1'b1) begin
                    errors++; $display("FAIL timing_underrun got=%b exp=1", underrun);
                end
            end
        end
    endtask

    task automatic test_preload();
        do_reset();
        run_to(16);
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 24'(17 * (i + 1));
            step();
            checks++;
            if (wr_ready !== (i < 3)) begin
                errors++; $display("FAIL preload_ready cyc=%0d got=%b exp=%b", cyc, wr_ready, (i < 3));
            end
        end
        wr_data = 24'h000055;
        run_to(39);
        checks++;
        if (wr_ready !== 1'b0) begin
            errors++; $display("FAIL preload_ready_full got=%b exp=0", wr_ready);
        end
        step();
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL preload_ready_swap got=%b exp=1", wr_ready);
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({pix_de, pix_data} !== {1'b1, 24'(17 * (i + 1))}) begin
                errors++; $display("FAIL preload_pixel cyc=%0d got=%b/%h exp=1/%h", cyc, pix_de, pix_data, 24'(17 * (i + 1)));
            end
        end
        step();
        checks++;
        if ({pix_de, pix_data} !== 25'h0) begin
            errors++; $display("FAIL preload_after_line got=%b/%h exp=0/000000", pix_de, pix_data);
        end
        run_to(49);
        checks++;
        if ({pix_de, pix_data} !== {1'b1, 24'h0}) begin
            errors++; $display("FAIL preload_stale got=%b/%h exp=1/000000", pix_de, pix_data);
        end
    endtask

    task automatic test_underrun_fill();
        do_reset();
        run_to(16);
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 24'(17 * (i + 1));
            step();
        end
        wr_valid = 1'b0;
        run_to(24);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL fill_clear got=%b exp=0", underrun);
        end
        run_to(40);
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 24'(32'hA1 + i);
            step();
        end
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL fill_ready_partial got=%b exp=1", wr_ready);
        end
        run_to(48);
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL fill_no_underrun got=%b exp=0", underrun);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({pix_de, pix_data} !== {1'b1, 24'h0}) begin
                errors++; $display("FAIL fill_blank_line cyc=%0d got=%b/%h exp=1/000000", cyc, pix_de, pix_data);
            end
        end
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL fill_underrun got=%b exp=1", underrun);
        end
        run_to(79);
        wr_valid = 1'b1;
        wr_data  = 24'h0000A4;
        step();
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++; $display("FAIL fill_swap_on_last got=%b exp=1", wr_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({pix_de, pix_data} !== {1'b1, 24'(32'hA1 + i)}) begin
                errors++; $display("FAIL fill_shown cyc=%0d got=%b/%h exp=1/%h", cyc, pix_de, pix_data, 24'(32'hA1 + i));
            end
        end
    endtask

    task automatic test_clr_priority();
        do_reset();
        clr_underrun = 1'b1;
        step();
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL clr_same_cycle got=%b exp=1", underrun);
        end
        step();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL clr_held got=%b exp=1", underrun);
        end
        run_to(19);
        clr_underrun = 1'b1;
        step();
        clr_underrun = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL clr_alone got=%b exp=0", underrun);
        end
        run_to(40);
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL clr_stays got=%b exp=0", underrun);
        end
        step();
        checks++;
        if (underrun !== 1'b1) begin
            errors++; $display("FAIL clr_reset got=%b exp=1", underrun);
        end
    endtask

    task automatic test_cs_drop();
        do_reset();
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 24'(17 * (i + 1));
            step();
        end
        wr_valid = 1'b0;
        run_to(9);
        checks++;
        if (pix_data !== 24'h000011) begin
            errors++; $display("FAIL cs_before_drop got=%h exp=000011", pix_data);
        end
        run_to(10);
        cs_display = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks += 3;
            if ({pix_de, hsync, vsync, frame_start, wr_ready} !== 5'b0) begin
                errors++; $display("FAIL cs_low_flags cyc=%0d got=%b exp=00000", cyc, {pix_de, hsync, vsync, frame_start, wr_ready});
            end
            if (pix_data !== 24'h0) begin
                errors++; $display("FAIL cs_low_data cyc=%0d got=%h exp=000000", cyc, pix_data);
            end
            if (underrun !== 1'b1) begin
                errors++; $display("FAIL cs_low_underrun cyc=%0d got=%b exp=1", cyc, underrun);
            end
        end
        cs_display = 1'b1;
        step();
        checks++;
        if ({frame_start, pix_de, wr_ready, pix_data} !== {3'b111, 24'h0}) begin
            errors++; $display("FAIL cs_restore got=%b%b%b/%h exp=111/000000", frame_start, pix_de, wr_ready, pix_data);
        end
        step();
        checks++;
        if ({frame_start, pix_de, pix_data} !== {2'b01, 24'h0}) begin
            errors++; $display("FAIL cs_restore_next got=%b%b/%h exp=01/000000", frame_start, pix_de, pix_data);
        end
        run_to(20);
        checks++;
        if (hsync !== 1'b1) begin
            errors++; $display("FAIL cs_restart_hsync got=%b exp=1", hsync);
        end
    endtask

`ifdef DISP_TEST_PATTERN_EN
    task automatic test_pattern_bars();
        logic [23:0] exp_bar [4];
        exp_bar[0] = 24'h000000;
        exp_bar[1] = 24'h00FF00;
        exp_bar[2] = 24'hFF0000;
        exp_bar[3] = 24'hFFFF00;
        do_reset();
        test_pattern = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({pix_de, pix_data} !== {1'b1, exp_bar[i]}) begin
                errors++; $display("FAIL pattern_bar px=%0d got=%b/%h exp=1/%h", i, pix_de, pix_data, exp_bar[i]);
            end
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++; $display("FAIL pattern_underrun got=%b exp=0", underrun);
        end
        test_pattern = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_timing();
        test_preload();
        test_underrun_fill();
        test_clr_priority();
        test_cs_drop();
`ifdef DISP_TEST_PATTERN_EN
        test_pattern_bars();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
